// File: rtl/bip_pkg.sv
// Shared BIP definitions: opcodes, loader state encoding, loader error codes.
package bip_pkg;

  localparam logic [4:0] OP_HALT = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;
  localparam logic [4:0] OP_MAX  = OP_SUBI;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } ld_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OPCODE   = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  function automatic logic opcode_valid(input logic [4:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/bip_program_loader.sv
// Packs received byte pairs into BIP instructions and writes them to program memory.
// Optional trailing XOR checksum after HALT when LOADER_CHECKSUM_EN is defined.
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int NB_OPCODE      = 5,
  parameter int NB_OPERAND     = 11,
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_BYTE        = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_mem_we,
  output logic [NB_ADDR-1:0]        o_mem_addr,
  output logic [NB_INSTRUCTION-1:0] o_mem_data,
  output logic                      o_busy,
  output logic                      o_cpu_en,
  output logic [1:0]                o_error,
  output logic [NB_ADDR:0]          o_count
);

  localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   COUNT_ONE = {{NB_ADDR{1'b0}}, 1'b1};

  ld_state_t             state;
  logic [NB_BYTE-1:0]    hi;
  logic [NB_ADDR-1:0]    addr;
  logic [NB_OPCODE-1:0]  rx_op;
  logic [NB_OPCODE-1:0]  hi_op;

  assign rx_op = i_rx_data[NB_BYTE-1 -: NB_OPCODE];
  assign hi_op = hi[NB_BYTE-1 -: NB_OPCODE];

`ifdef LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]    csum;

  // Running XOR of every instruction byte of the current load.
  always_ff @(posedge i_clock) begin
    if (i_reset)
      csum <= '0;
    else if (i_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR))
      csum <= '0;
    else if (i_rx_valid && (state == ST_HIGH || state == ST_LOW))
      csum <= csum ^ i_rx_data;
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      hi         <= '0;
      addr       <= '0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_busy     <= 1'b0;
      o_cpu_en   <= 1'b0;
      o_error    <= ERR_NONE;
      o_count    <= '0;
    end else begin
      o_mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            state    <= ST_HIGH;
            addr     <= '0;
            o_count  <= '0;
            o_error  <= ERR_NONE;
            o_busy   <= 1'b1;
            o_cpu_en <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (i_rx_valid) begin
            hi <= i_rx_data;
            if (!opcode_valid(rx_op)) begin
              state   <= ST_ERROR;
              o_error <= ERR_OPCODE;
              o_busy  <= 1'b0;
            end else begin
              state <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (i_rx_valid) begin
            // The write is issued even on the overflowing slot.
            o_mem_we   <= 1'b1;
            o_mem_addr <= addr;
            o_mem_data <= {hi, i_rx_data};
            o_count    <= o_count + COUNT_ONE;
            if (hi_op == OP_HALT) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= ST_CHECK;
`else
              state    <= ST_DONE;
              o_busy   <= 1'b0;
              o_cpu_en <= 1'b1;
`endif
            end else if (addr == ADDR_LAST) begin
              state   <= ST_ERROR;
              o_error <= ERR_OVERFLOW;
              o_busy  <= 1'b0;
            end else begin
              addr  <= addr + ADDR_ONE;
              state <= ST_HIGH;
            end
          end
        end
        ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (i_rx_valid) begin
            o_busy <= 1'b0;
            if (i_rx_data == csum) begin
              state    <= ST_DONE;
              o_cpu_en <= 1'b1;
            end else begin
              state   <= ST_ERROR;
              o_error <= ERR_CHECKSUM;
            end
          end
`else
          state  <= ST_IDLE;
          o_busy <= 1'b0;
`endif
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bip_program_loader.md
# bip_program_loader

Byte-stream program loader for the BIP processor. It receives program bytes from the UART receiver, packs each pair of bytes into one 16-bit instruction, and validates the opcode. It writes each valid instruction sequentially into program memory and, once a HALT instruction has been stored, releases the CPU. It is the producing end of the instruction stream that the BIP control path fetches and decodes.

## Interface
Parameters:
- NB_OPCODE, 5, opcode field width
- NB_OPERAND, 11, operand field width
- NB_INSTRUCTION, 16, instruction word width (NB_OPCODE + NB_OPERAND)
- NB_ADDR, 11, program memory address width
- NB_BYTE, 8, received byte width

Ports:
- i_clock  in  1  single clock; all logic is on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
- i_rx_data  in  NB_BYTE  received byte; valid when i_rx_valid is high
- i_rx_valid  in  1  one-cycle strobe per byte; no backpressure
- o_mem_we  out  1  program memory write enable, one cycle per instruction
- o_mem_addr  out  NB_ADDR  write address
- o_mem_data  out  NB_INSTRUCTION  instruction word {opcode, operand}
- o_busy  out  1  high in HIGH, LOW and CHECK
- o_cpu_en  out  1  high in DONE; enables the CPU
- o_error  out  2  0 none, 1 bad opcode, 2 overflow, 3 checksum
- o_count  out  NB_ADDR+1  number of instructions written in the current load

## Operation
- States: IDLE, HIGH (awaiting high byte), LOW (awaiting low byte), CHECK (macro only), DONE, ERROR.
- Byte order: high byte first, {opcode[4:0], operand[10:8]}, then low byte operand[7:0].
- Transitions:
  - IDLE, DONE or ERROR + i_start: go to HIGH; clear address, o_count and o_error.
  - HIGH + strobe: latch the byte. If the opcode is greater than 7 (valid opcodes are HALT=0 through SUBI=7), go to ERROR with code 1. Otherwise go to LOW.
  - LOW + strobe: register the write of {hi, lo} at the current address.
    - If the opcode is HALT: go to CHECK (macro defined) or DONE.
    - Else if the address equals 2^NB_ADDR-1: go to ERROR with code 2. The instruction is still written.
    - Else: increment the address and go to HIGH.
- Strobes in IDLE, DONE and ERROR are ignored. i_start in HIGH, LOW or CHECK is ignored.
- o_count increments with every write. The address does not wrap.
- A bad opcode is never written to memory.

## Timing
- Reset values: state IDLE, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_busy=0, o_cpu_en=0, o_error=0, o_count=0.
- All outputs are registered.
- o_mem_we is high for exactly one cycle, the cycle after the low-byte strobe. Address and data are stable during that cycle.
- Strobes can arrive on consecutive cycles. A high-byte strobe during the o_mem_we cycle is accepted normally, with no loss.
- o_cpu_en rises in the same cycle as the HALT write's o_mem_we (macro off), or the cycle after the checksum strobe (macro on).
- o_cpu_en falls the cycle after i_start is accepted.
- Reset mid-load aborts immediately; no further write is issued.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A running XOR of all received instruction bytes is kept.
  - After HALT, state CHECK waits for one more byte.
  - If the byte equals the XOR: go to DONE.
  - If it differs: go to ERROR with code 3. Instructions already written stay in memory; o_cpu_en stays low.
- LOADER_CHECKSUM_EN undefined: the CHECK state and accumulator are absent, and HALT leads directly to DONE.

## Structure
- Shared package bip_pkg holds:
  - BIP opcode constants (HALT..SUBI)
  - the highest valid opcode
  - loader state encoding
  - error-code constants
  - a validity function on the opcode
- A single module, no sub-module. The checksum accumulator is a few lines inside the macro guard.

## Test plan
- Basic load: start, then bytes 0x18 0x05, 0x20 0x0A, 0x00 0x00.
  - Writes 0x1805 at 0, 0x200A at 1, 0x0000 at 2.
  - o_count=3, o_cpu_en=1, o_error=0.
- Bad opcode: high byte 0x48 (opcode 9).
  - No write; ERROR with o_error=1.
  - A later start clears the error and restarts at address 0.
- Back-to-back strobes: bytes on consecutive cycles.
  - Every pair is written; o_mem_we pulses are exactly one cycle and none are lost.
- Overflow with NB_ADDR=2: four non-HALT instructions.
  - Fourth is written at address 3, then o_error=2 and o_cpu_en=0.
- Reset after one byte of the second instruction.
  - All outputs return to reset values; no write occurs.
- LOADER_CHECKSUM_EN: program 0x18 0x05, 0x00 0x00.
  - Checksum 0x1D gives DONE.
  - Checksum 0x1C gives o_error=3, o_cpu_en=0.
